csr_file: RTL and testbench

Parametrised machine-mode CSR file for the core and the successor to the fixed-width CSR register block. It executes the CSRRW/CSRRS/CSRRC read-modify-write internally from an operation code, applies per-register write masks, and flags illegal accesses. It also performs trap entry and MRET updates of mepc, mcause and mstatus atomically, and provides mcycle/minstret counters of configurable width. It sits between exu (CSR instructions) and clint (trap/return sequencing) and drives mtvec/mepc/mstatus to the fetch and interrupt logic.

---
 rtl/csr_pkg.sv | 59 +++++
 rtl/csr_counter.sv | 36 +++
 rtl/csr_file.sv | 175 +++++++++++++++++
 tb/tb_csr_file.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op codes,
// mstatus field positions, write masks and the read-modify-write helper.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Operation encoding as driven by exu
  typedef enum logic [1:0] {
    CSR_OP_RW = 2'd0,
    CSR_OP_RS = 2'd1,
    CSR_OP_RC = 2'd2,
    CSR_OP_RD = 2'd3
  } csr_op_e;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Reset value: MPP fixed at machine mode, interrupts disabled
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  // Writable bits of each register
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

  // New value for a CSRRW/CSRRS/CSRRC given the old value and the operand
  function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] old_val,
                                               logic [31:0] operand);
    logic [31:0] result;
    case (op)
      CSR_OP_RW: result = operand;
      CSR_OP_RS: result = old_val | operand;
      CSR_OP_RC: result = old_val & ~operand;
      default:   result = old_val;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter of configurable width with independently writable
// low and high halves; a write takes the place of the increment that cycle.
module csr_counter
  import csr_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  // Counter state: half writes override the increment, natural wrap to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (wr_lo_i) begin
      count_q[31:0] <= wdata_i;
    end else if (wr_hi_i) begin
      count_q[WIDTH-1:32] <= wdata_i[WIDTH-33:0];
    end else if (inc_i) begin
      count_q <= count_q + ONE;
    end
  end

  assign value_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: executes CSR read-modify-write ops from exu,
// applies write masks, flags illegal accesses, and performs trap entry and
// MRET updates of mepc/mcause/mstatus. Hosts mcycle/minstret counters.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter int          NUM_SCRATCH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instret_i,
  input  logic        trap_enter_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mie_o,
  output logic        global_int_en_o
);

  logic [31:0] mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q;
  logic [31:0] scratch0_q, scratch1_q;
  logic [CNT_WIDTH-1:0] mcycle_val, minstret_val;
  logic [63:0] mcycle_ext, minstret_ext;

  csr_op_e     op;
  logic [31:0] rdata_raw;
  logic        implemented;
  logic        read_only;
  logic        ro_write;
  logic        csr_we;
  logic [31:0] wval;

  assign op           = csr_op_e'(csr_op_i);
  assign mcycle_ext   = 64'(mcycle_val);
  assign minstret_ext = 64'(minstret_val);

  // Address decode and read mux from current state
  always_comb begin
    rdata_raw   = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS:   rdata_raw = mstatus_q;
      CSR_MIE:       rdata_raw = mie_q;
      CSR_MTVEC:     rdata_raw = mtvec_q;
      CSR_MSCRATCH:  rdata_raw = scratch0_q;
      CSR_MEPC:      rdata_raw = mepc_q;
      CSR_MCAUSE:    rdata_raw = mcause_q;
      CSR_DSCRATCH0: begin
        if (NUM_SCRATCH > 1) rdata_raw = scratch1_q;
        else                 implemented = 1'b0;
      end
      CSR_MCYCLE:    rdata_raw = mcycle_ext[31:0];
      CSR_MCYCLEH:   rdata_raw = mcycle_ext[63:32];
      CSR_MINSTRET:  rdata_raw = minstret_ext[31:0];
      CSR_MINSTRETH: rdata_raw = minstret_ext[63:32];
      CSR_CYCLE:     begin rdata_raw = mcycle_ext[31:0];    read_only = 1'b1; end
      CSR_CYCLEH:    begin rdata_raw = mcycle_ext[63:32];   read_only = 1'b1; end
      CSR_INSTRET:   begin rdata_raw = minstret_ext[31:0];  read_only = 1'b1; end
      CSR_INSTRETH:  begin rdata_raw = minstret_ext[63:32]; read_only = 1'b1; end
      CSR_MHARTID:   begin rdata_raw = HART_ID;             read_only = 1'b1; end
      default:       implemented = 1'b0;
    endcase
  end

  // A read-only CSR may still be touched by CSRRS/CSRRC with a zero operand
  assign ro_write = read_only &&
                    ((op == CSR_OP_RW) ||
                     (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (csr_wdata_i != 32'h0)));

  assign csr_illegal_o = csr_req_i && (!implemented || ro_write);
  assign csr_rdata_o   = csr_req_i ? rdata_raw : 32'h0;

  // exu write is dropped when the pipeline is flushed by a trap or MRET
  assign csr_we = csr_req_i && !csr_illegal_o && (op != CSR_OP_RD) && !read_only &&
                  !trap_enter_i && !mret_i;
  assign wval   = csr_apply_op(op, rdata_raw, csr_wdata_i);

  // mstatus: trap entry beats MRET beats exu write; only MIE/MPIE are writable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q <= MSTATUS_RESET;
    end else if (trap_enter_i) begin
      mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
      mstatus_q[MSTATUS_MIE]  <= 1'b0;
    end else if (mret_i) begin
      mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
      mstatus_q[MSTATUS_MPIE] <= 1'b1;
    end else if (csr_we && csr_addr_i == CSR_MSTATUS) begin
      mstatus_q <= (mstatus_q & ~MSTATUS_WMASK) | (wval & MSTATUS_WMASK);
    end
  end

  // mepc/mcause: captured on trap entry, otherwise software writable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_enter_i) begin
      mepc_q   <= trap_pc_i & MEPC_WMASK;
      mcause_q <= trap_cause_i;
    end else if (csr_we) begin
      if (csr_addr_i == CSR_MEPC)   mepc_q   <= wval & MEPC_WMASK;
      if (csr_addr_i == CSR_MCAUSE) mcause_q <= wval;
    end
  end

  // mtvec/mie/mscratch: plain masked software registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
      mie_q      <= '0;
      scratch0_q <= '0;
    end else if (csr_we) begin
      if (csr_addr_i == CSR_MTVEC)    mtvec_q    <= wval & MTVEC_WMASK;
      if (csr_addr_i == CSR_MIE)      mie_q      <= wval & MIE_WMASK;
      if (csr_addr_i == CSR_MSCRATCH) scratch0_q <= wval;
    end
  end

  // Optional second scratch register at the dscratch0 address
  generate
    if (NUM_SCRATCH > 1) begin : g_scratch1
      // dscratch0 storage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          scratch1_q <= '0;
        end else if (csr_we && csr_addr_i == CSR_DSCRATCH0) begin
          scratch1_q <= wval;
        end
      end
    end else begin : g_no_scratch1
      assign scratch1_q = '0;
    end
  endgenerate

  csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (csr_we && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (wval),
    .value_o (mcycle_val)
  );

  csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instret_i),
    .wr_lo_i (csr_we && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (csr_we && csr_addr_i == CSR_MINSTRETH),
    .wdata_i (wval),
    .value_o (minstret_val)
  );

  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_q;
  assign mie_o           = mie_q;
  assign global_int_en_o = mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file with hand-computed expected values.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        instret_i;
  logic        trap_enter_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic        mret_i;
  logic [31:0] mtvec_o, mepc_o, mstatus_o, mie_o;
  logic        global_int_en_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_file #(
    .HART_ID     (32'h5),
    .CNT_WIDTH   (33),
    .MTVEC_RESET (32'h0000_1003),
    .NUM_SCRATCH (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_req_i       (csr_req_i),
    .csr_op_i        (csr_op_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rdata_o     (csr_rdata_o),
    .csr_illegal_o   (csr_illegal_o),
    .instret_i       (instret_i),
    .trap_enter_i    (trap_enter_i),
    .trap_cause_i    (trap_cause_i),
    .trap_pc_i       (trap_pc_i),
    .mret_i          (mret_i),
    .mtvec_o         (mtvec_o),
    .mepc_o          (mepc_o),
    .mstatus_o       (mstatus_o),
    .mie_o           (mie_o),
    .global_int_en_o (global_int_en_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read within the current cycle; no edge consumed
  task automatic rd(input logic [11:0] addr, output logic [31:0] data, output logic ill);
    csr_req_i  = 1'b1;
    csr_op_i   = 2'd3;
    csr_addr_i = addr;
    #1;
    data = csr_rdata_o;
    ill  = csr_illegal_o;
    csr_req_i = 1'b0;
    #1;
  endtask

  // One-cycle CSR write request; result visible on return
  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
    csr_req_i   = 1'b1;
    csr_op_i    = op;
    csr_addr_i  = addr;
    csr_wdata_i = wdata;
    tick();
    csr_req_i   = 1'b0;
    csr_wdata_i = '0;
  endtask

  logic [31:0] d;
  logic        il;

  initial begin
    rst_n = 1'b0;
    csr_req_i = 1'b0; csr_op_i = 2'd0; csr_addr_i = '0; csr_wdata_i = '0;
    instret_i = 1'b0; trap_enter_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0;
    mret_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mstatus_o", mstatus_o, 32'h1800);
    check("rst_mtvec_o", mtvec_o, 32'h1000);
    check("rst_mepc_o", mepc_o, 32'h0);
    check("rst_mie_o", mie_o, 32'h0);
    check("rst_gie", 32'(global_int_en_o), 32'h0);
    check("rst_rdata_idle", csr_rdata_o, 32'h0);
    rst_n = 1'b1;
    tick();

    rd(12'h300, d, il); check("rd_mstatus", d, 32'h1800); check("rd_mstatus_ill", 32'(il), 0);
    rd(12'h305, d, il); check("rd_mtvec", d, 32'h1000);
    rd(12'hF14, d, il); check("rd_mhartid", d, 32'h5);  check("rd_mhartid_ill", 32'(il), 0);

    wr(2'd1, 12'h300, 32'h8);
    rd(12'h300, d, il); check("rs_mstatus", d, 32'h1808);
    check("rs_gie", 32'(global_int_en_o), 32'h1);
    wr(2'd2, 12'h300, 32'h8);
    rd(12'h300, d, il); check("rc_mstatus", d, 32'h1800);
    wr(2'd0, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, d, il); check("rw_mstatus_mask", d, 32'h1888);

    wr(2'd0, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, d, il); check("rw_mie_mask", d, 32'h888);
    check("mie_o", mie_o, 32'h888);
    wr(2'd0, 12'h305, 32'h0000_1237);
    check("rw_mtvec_mask", mtvec_o, 32'h1234);

    // Trap entry with MIE=1
    trap_enter_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h1003;
    tick();
    trap_enter_i = 1'b0;
    check("trap_mepc_o", mepc_o, 32'h1000);
    check("trap_mstatus", mstatus_o, 32'h1880);
    check("trap_gie", 32'(global_int_en_o), 32'h0);
    rd(12'h342, d, il); check("trap_mcause", d, 32'h8000_0007);
    rd(12'h341, d, il); check("trap_rd_mepc", d, 32'h1000);

    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    check("mret_mstatus", mstatus_o, 32'h1888);

    // Clear MIE, then trap + mret + exu write in one cycle
    wr(2'd2, 12'h300, 32'h8);
    check("pre_combo_mstatus", mstatus_o, 32'h1880);
    trap_enter_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'hB; trap_pc_i = 32'h2002;
    csr_req_i = 1'b1; csr_op_i = 2'd0; csr_addr_i = 12'h340; csr_wdata_i = 32'h55;
    tick();
    trap_enter_i = 1'b0; mret_i = 1'b0; csr_req_i = 1'b0;
    check("combo_mstatus", mstatus_o, 32'h1800);
    check("combo_mepc", mepc_o, 32'h2000);
    rd(12'h340, d, il); check("combo_mscratch", d, 32'h0);

    wr(2'd0, 12'h7B2, 32'hAA);
    rd(12'h7B2, d, il); check("dscratch0", d, 32'hAA);
    check("dscratch0_ill", 32'(il), 0);
    rd(12'h340, d, il); check("mscratch_untouched", d, 32'h0);

    // 33-bit counter wrap
    wr(2'd0, 12'hB00, 32'hFFFF_FFFF);
    wr(2'd0, 12'hB80, 32'h1);
    rd(12'hB00, d, il); check("mcycle_max_lo", d, 32'hFFFF_FFFF);
    rd(12'hB80, d, il); check("mcycle_max_hi", d, 32'h1);
    tick();
    rd(12'hB00, d, il); check("mcycle_wrap_lo", d, 32'h0);
    rd(12'hB80, d, il); check("mcycle_wrap_hi", d, 32'h0);
    rd(12'hC80, d, il); check("cycleh_wrap", d, 32'h0);

    // Read-only cycle: RW illegal, RS with zero operand legal
    wr(2'd0, 12'hB00, 32'h100);
    csr_req_i = 1'b1; csr_op_i = 2'd0; csr_addr_i = 12'hC00; csr_wdata_i = 32'hABCD;
    #1;
    check("cycle_rw_ill", 32'(csr_illegal_o), 32'h1);
    check("cycle_rw_rdata", csr_rdata_o, 32'h100);
    tick();
    csr_op_i = 2'd1; csr_wdata_i = 32'h0;
    #1;
    check("cycle_rs0_ill", 32'(csr_illegal_o), 32'h0);
    check("cycle_rs0_rdata", csr_rdata_o, 32'h101);
    csr_req_i = 1'b0;
    rd(12'hB00, d, il); check("mcycle_after_ill", d, 32'h101);

    // minstret
    instret_i = 1'b1;
    repeat (3) tick();
    instret_i = 1'b0;
    rd(12'hB02, d, il); check("minstret", d, 32'h3);
    rd(12'hC02, d, il); check("instret", d, 32'h3);
    rd(12'hC82, d, il); check("instreth", d, 32'h0);

    // Unimplemented address
    csr_req_i = 1'b1; csr_op_i = 2'd0; csr_addr_i = 12'h7C0; csr_wdata_i = 32'hFFFF_FFFF;
    #1;
    check("unimpl_rdata", csr_rdata_o, 32'h0);
    check("unimpl_ill", 32'(csr_illegal_o), 32'h1);
    tick();
    csr_req_i = 1'b0;
    check("unimpl_mstatus", mstatus_o, 32'h1800);
    check("unimpl_mie", mie_o, 32'h888);
    check("unimpl_mtvec", mtvec_o, 32'h1234);
    rd(12'h340, d, il); check("unimpl_mscratch", d, 32'h0);

    // mhartid write illegal
    csr_req_i = 1'b1; csr_op_i = 2'd0; csr_addr_i = 12'hF14; csr_wdata_i = 32'h0;
    #1;
    check("mhartid_rw_ill", 32'(csr_illegal_o), 32'h1);
    csr_req_i = 1'b0;

    // Asynchronous reset mid-cycle
    wr(2'd1, 12'h300, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mstatus", mstatus_o, 32'h1800);
    check("async_rst_mie", mie_o, 32'h0);
    check("async_rst_mtvec", mtvec_o, 32'h1000);
    check("async_rst_mepc", mepc_o, 32'h0);
    tick();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
